// File: rtl/temp_sampler.sv
// Conditions raw signed ADC samples into a saturated Q7.0 temperature stream with plausibility
// checking, a stall watchdog and an init strobe for the downstream dT estimator.
module temp_sampler #(
    parameter int unsigned ADC_W     = 12,
    parameter int unsigned FRAC_BITS = 4,
    parameter int unsigned AVG_LOG2  = 2,
    parameter int unsigned TIMEOUT   = 1024,
    parameter int unsigned RECOVER_N = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [ADC_W-1:0] adc_data,
    input  logic                    adc_valid,
    input  logic signed [7:0]       T_lo,
    input  logic signed [7:0]       T_hi,
    output logic signed [7:0]       T_cur,
    output logic                    t_valid,
    output logic                    init,
    output logic                    fault
);

    localparam int unsigned ACC_W = ADC_W + AVG_LOG2;
    localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned GC_W  = $clog2(RECOVER_N + 1);
    localparam int unsigned SHIFT = AVG_LOG2 + FRAC_BITS;

    localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT);
    localparam logic [GC_W-1:0]  GC_LAST  = GC_W'(RECOVER_N - 1);

    localparam logic [1:0] ST_WARMUP = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_FAULT  = 2'd2;

    logic [1:0]             r_state;
    logic signed [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0]       r_blk_cnt;
    logic [WD_W-1:0]        r_wdog;
    logic [GC_W-1:0]        r_good_cnt;
    logic signed [7:0]      r_t_cur;
    logic                   r_t_valid;
    logic                   r_init;

    logic [1:0]             w_state;
    logic signed [ACC_W-1:0] w_acc;
    logic [CNT_W-1:0]       w_blk_cnt;
    logic [WD_W-1:0]        w_wdog;
    logic [GC_W-1:0]        w_good_cnt;
    logic signed [7:0]      w_t_cur;
    logic                   w_t_valid;
    logic                   w_init;

    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_shift;
    logic signed [31:0]     w_val;
    logic signed [7:0]      w_sat;
    logic                   w_blk_done;
    logic                   w_good;
    logic                   w_stall;

    assign w_blk_done = adc_valid && (r_blk_cnt == BLK_LAST);
    // Stall fires once, on the idle clock that carries the count up to TIMEOUT.
    assign w_stall    = !adc_valid && (r_wdog == WD_LIMIT - 1'b1);

    always_comb begin
        w_sum   = r_acc + ACC_W'(adc_data);
        w_shift = w_sum >>> SHIFT;
        w_val   = 32'(w_shift);
        if (w_val > 127) begin
            w_sat = 8'sd127;
        end else if (w_val < -128) begin
            w_sat = -8'sd128;
        end else begin
            w_sat = w_val[7:0];
        end
        w_good = (w_sat >= T_lo) && (w_sat <= T_hi);
    end

    always_comb begin
        w_acc     = r_acc;
        w_blk_cnt = r_blk_cnt;
        if (w_stall) begin
            w_acc     = '0;
            w_blk_cnt = '0;
        end else if (adc_valid) begin
            w_acc     = w_blk_done ? '0 : w_sum;
            w_blk_cnt = w_blk_done ? '0 : r_blk_cnt + 1'b1;
        end

        w_wdog = r_wdog;
        if (adc_valid) begin
            w_wdog = '0;
        end else if (r_wdog != WD_LIMIT) begin
            w_wdog = r_wdog + 1'b1;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_good_cnt = r_good_cnt;
        w_t_cur    = r_t_cur;
        w_t_valid  = 1'b0;
        w_init     = 1'b0;
        if (w_stall) begin
            w_state    = ST_FAULT;
            w_good_cnt = '0;
        end else if (w_blk_done) begin
            case (r_state)
                ST_WARMUP, ST_RUN: begin
                    if (w_good) begin
                        w_state   = ST_RUN;
                        w_t_cur   = w_sat;
                        w_t_valid = 1'b1;
                        w_init    = (r_state == ST_WARMUP);
                    end else begin
                        w_state    = ST_FAULT;
                        w_good_cnt = '0;
                    end
                end
                ST_FAULT: begin
                    if (!w_good) begin
                        w_good_cnt = '0;
                    end else if (r_good_cnt == GC_LAST) begin
                        w_state    = ST_RUN;
                        w_good_cnt = '0;
                        w_t_cur    = w_sat;
                        w_t_valid  = 1'b1;
                        w_init     = 1'b1;
                    end else begin
                        w_good_cnt = r_good_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state    = ST_FAULT;
                    w_good_cnt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_WARMUP;
            r_acc      <= '0;
            r_blk_cnt  <= '0;
            r_wdog     <= '0;
            r_good_cnt <= '0;
            r_t_cur    <= '0;
            r_t_valid  <= 1'b0;
            r_init     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_acc      <= w_acc;
            r_blk_cnt  <= w_blk_cnt;
            r_wdog     <= w_wdog;
            r_good_cnt <= w_good_cnt;
            r_t_cur    <= w_t_cur;
            r_t_valid  <= w_t_valid;
            r_init     <= w_init;
        end
    end

    assign T_cur   = r_t_cur;
    assign t_valid = r_t_valid;
    assign init    = r_init;
    assign fault   = (r_state == ST_FAULT);

endmodule

// File: tb/tb_temp_sampler.sv
// Bench for temp_sampler: directed scenarios plus random traffic, checked every cycle against a
// block/queue-level model of the sampler.
module tb_temp_sampler;

    localparam int ADC_W     = 12;
    localparam int FRAC_BITS = 4;
    localparam int AVG_LOG2  = 2;
    localparam int TIMEOUT   = 1024;
    localparam int RECOVER_N = 2;
    localparam int BLK       = 1 << AVG_LOG2;
    localparam int DIV       = 1 << (AVG_LOG2 + FRAC_BITS);

    logic                    clk = 1'b0;
    logic                    rst;
    logic signed [ADC_W-1:0] adc_data;
    logic                    adc_valid;
    logic signed [7:0]       T_lo;
    logic signed [7:0]       T_hi;
    logic signed [7:0]       T_cur;
    logic                    t_valid;
    logic                    init;
    logic                    fault;

    temp_sampler #(
        .ADC_W     (ADC_W),
        .FRAC_BITS (FRAC_BITS),
        .AVG_LOG2  (AVG_LOG2),
        .TIMEOUT   (TIMEOUT),
        .RECOVER_N (RECOVER_N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .adc_data  (adc_data),
        .adc_valid (adc_valid),
        .T_lo      (T_lo),
        .T_hi      (T_hi),
        .T_cur     (T_cur),
        .t_valid   (t_valid),
        .init      (init),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_q[$];
    int m_idle;
    bit m_faulted;
    bit m_started;
    int m_good_run;
    int m_t;
    bit m_tv;
    bit m_init;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int floor_div(input int num, input int den);
        int q;
        q = num / den;
        if ((num % den != 0) && (num < 0)) q = q - 1;
        return q;
    endfunction

    task automatic model_block(input int val);
        bit good;
        good = (val >= int'(T_lo)) && (val <= int'(T_hi));
        if (!m_faulted) begin
            if (good) begin
                m_t       = val;
                m_tv      = 1'b1;
                m_init    = !m_started;
                m_started = 1'b1;
            end else begin
                m_faulted  = 1'b1;
                m_good_run = 0;
            end
        end else if (!good) begin
            m_good_run = 0;
        end else begin
            m_good_run++;
            if (m_good_run == RECOVER_N) begin
                m_faulted  = 1'b0;
                m_good_run = 0;
                m_t        = val;
                m_tv       = 1'b1;
                m_init     = 1'b1;
                m_started  = 1'b1;
            end
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_edge();
        int sum;
        int val;
        m_tv   = 1'b0;
        m_init = 1'b0;
        if (rst) begin
            m_q.delete();
            m_idle     = 0;
            m_faulted  = 1'b0;
            m_started  = 1'b0;
            m_good_run = 0;
            m_t        = 0;
        end else if (adc_valid) begin
            m_idle = 0;
            m_q.push_back(int'(adc_data));
            if (m_q.size() == BLK) begin
                sum = 0;
                foreach (m_q[i]) sum += m_q[i];
                m_q.delete();
                val = floor_div(sum, DIV);
                if (val > 127) val = 127;
                if (val < -128) val = -128;
                model_block(val);
            end
        end else if (m_idle < TIMEOUT) begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
                m_q.delete();
                m_good_run = 0;
                m_faulted  = 1'b1;
            end
        end
    endtask

    task automatic step(input bit v, input int d);
        adc_valid = v;
        adc_data  = ADC_W'(d);
        model_edge();
        @(posedge clk);
        #1;
        check("t_cur", int'(T_cur), m_t);
        check("t_valid", int'(t_valid), int'(m_tv));
        check("init", int'(init), int'(m_init));
        check("fault", int'(fault), int'(m_faulted));
    endtask

    task automatic block(input int d);
        for (int i = 0; i < BLK; i++) step(1'b1, d);
    endtask

    initial begin
        rst       = 1'b1;
        adc_valid = 1'b0;
        adc_data  = '0;
        T_lo      = -8'sd128;
        T_hi      = 8'sd127;
        step(1'b0, 0);
        step(1'b0, 0);
        check("rst_tcur", int'(T_cur), 0);
        check("rst_fault", int'(fault), 0);
        rst = 1'b0;

        // T1 first good block after reset
        block(400);
        check("t1_tcur", int'(T_cur), 25);
        check("t1_tvalid", int'(t_valid), 1);
        check("t1_init", int'(init), 1);
        check("t1_fault", int'(fault), 0);
        step(1'b0, 0);
        check("t1_pulse", int'(t_valid), 0);

        // T2 rounding and saturation in RUN
        block(408);
        check("t2_tcur_a", int'(T_cur), 25);
        check("t2_init_a", int'(init), 0);
        block(-8);
        check("t2_tcur_b", int'(T_cur), -1);
        block(-2048);
        check("t2_tcur_c", int'(T_cur), -128);

        // T3 implausible block then recovery
        T_hi = 8'sd100;
        block(1800);
        check("t3_fault", int'(fault), 1);
        check("t3_tvalid", int'(t_valid), 0);
        check("t3_hold", int'(T_cur), -128);
        block(400);
        check("t3_silent", int'(t_valid), 0);
        block(400);
        check("t3_rec_tv", int'(t_valid), 1);
        check("t3_rec_init", int'(init), 1);
        check("t3_rec_fault", int'(fault), 0);

        // T4 stall after a partial block
        step(1'b1, 400);
        step(1'b1, 400);
        for (int i = 0; i < TIMEOUT - 1; i++) step(1'b0, 0);
        check("t4_pre_stall", int'(fault), 0);
        step(1'b0, 0);
        check("t4_stall", int'(fault), 1);
        block(400);
        check("t4_fresh_a", int'(t_valid), 0);
        block(400);
        check("t4_fresh_b", int'(t_valid), 1);

        // T5 valid in the would-be stall cycle, then inverted limits
        for (int i = 0; i < TIMEOUT - 1; i++) step(1'b0, 0);
        step(1'b1, 400);
        check("t5_no_stall", int'(fault), 0);
        for (int i = 0; i < BLK - 1; i++) step(1'b1, 400);
        check("t5_tvalid", int'(t_valid), 1);
        T_lo = 8'sd10;
        T_hi = 8'sd5;
        block(120);
        check("t5_inv_fault", int'(fault), 1);
        block(120);
        block(120);
        check("t5_inv_silent", int'(t_valid), 0);
        T_lo = -8'sd128;
        T_hi = 8'sd127;

        // T6 reset mid-block
        for (int i = 0; i < 3; i++) step(1'b1, 400);
        rst = 1'b1;
        step(1'b1, 400);
        rst = 1'b0;
        check("t6_rst_fault", int'(fault), 0);
        check("t6_rst_tcur", int'(T_cur), 0);
        block(400);
        check("t6_tvalid", int'(t_valid), 1);
        check("t6_init", int'(init), 1);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            if (n % 150 == 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    T_lo = 8'($urandom_range(0, 255));
                    T_hi = 8'($urandom_range(0, 255));
                end else begin
                    T_lo = -8'sd40;
                    T_hi = 8'sd60;
                end
            end
            if ($urandom_range(0, 999) == 0) begin
                for (int i = 0; i < TIMEOUT + 3; i++) step(1'b0, 0);
            end
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 3) == 0) begin
                step(1'b0, 0);
            end else if ($urandom_range(0, 4) == 0) begin
                step(1'b1, int'($urandom_range(0, 4095)));
            end else begin
                step(1'b1, int'($urandom_range(0, 1600)) - 600);
            end
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
